// File: rtl/iter_mdu.sv
// ---------------------------------------------------------------------------
// iter_mdu
// Iterative multiply/divide unit with HI/LO result registers.
// Each arithmetic op takes W radix-2 steps plus one fixup cycle. The fixup
// cycle applies sign correction or the accumulate, then commits HI/LO.
//
// Ports:
//    clk     : clock, all state updates on the rising edge
//    reset   : synchronous, active-high reset
//    start   : launch the arithmetic op presented on op
//    we      : write strobe for mthi/mtlo (op 3/4), taken only when idle
//    cancel  : abort the in-flight op; suppresses a start while idle
//    op      : 1 mult, 2 div, 3 mthi, 4 mtlo, 5 multu, 6 divu,
//              7 madd, 8 maddu, 9 msub, 10 msubu
//    a, b    : operands (a also carries mthi/mtlo data)
//    busy    : op in flight
//    done    : one-cycle pulse after HI/LO have been committed
//    hi, lo  : committed HI/LO registers
// ---------------------------------------------------------------------------
module iter_mdu #(
   parameter int W       = 32,
   parameter bit EN_MACC = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         we,
   input  logic         cancel,
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int CW = $clog2(W + 2);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_MULTU = 4'd5;
   localparam logic [3:0] OP_DIVU  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t         r_state;
   state_t         w_nextState;

   logic [CW-1:0]  r_count;
   logic [3:0]     r_op;
   logic [2*W-1:0] r_work;
   logic [W-1:0]   r_opB;
   logic           r_negRes;
   logic           r_negRem;
   logic [W-1:0]   r_hi;
   logic [W-1:0]   r_lo;
   logic           r_done;

   logic           w_isMul;
   logic           w_isDiv;
   logic           w_isSigned;
   logic           w_aNeg;
   logic           w_bNeg;
   logic [W-1:0]   w_aMag;
   logic [W-1:0]   w_bMag;
   logic           w_divZero;
   logic           w_accept;
   logic           w_launch;
   logic           w_lastStep;
   logic           w_commit;
   logic           w_wrHi;
   logic           w_wrLo;
   logic           w_runIsDiv;

   logic [W:0]     w_mulSum;
   logic [2*W-1:0] w_mulStep;
   logic [W:0]     w_remSh;
   logic           w_remGe;
   logic [W-1:0]   w_diff;
   logic [2*W-1:0] w_divStep;
   logic [2*W-1:0] w_prod;
   logic [W-1:0]   w_quo;
   logic [W-1:0]   w_rem;
   logic [2*W-1:0] w_result;

   // Decode the incoming request and work out which of the idle-state
   // actions (launch, mthi/mtlo write) this cycle carries. A start always
   // swallows a simultaneous we, even if the start itself is ignored.
   // A legal divide by zero is accepted but never enters RUN.
   always_comb begin
      w_isMul    = 1'b0;
      w_isDiv    = 1'b0;
      w_isSigned = 1'b0;
      case (op)
         OP_MULT:  begin w_isMul = 1'b1; w_isSigned = 1'b1; end
         OP_MULTU: w_isMul = 1'b1;
         OP_DIV:   begin w_isDiv = 1'b1; w_isSigned = 1'b1; end
         OP_DIVU:  w_isDiv = 1'b1;
         OP_MADD,
         OP_MSUB:  begin w_isMul = EN_MACC; w_isSigned = EN_MACC; end
         OP_MADDU,
         OP_MSUBU: w_isMul = EN_MACC;
         default:  ;
      endcase
      w_aNeg     = w_isSigned & a[W-1];
      w_bNeg     = w_isSigned & b[W-1];
      w_aMag     = w_aNeg ? (~a + 1'b1) : a;
      w_bMag     = w_bNeg ? (~b + 1'b1) : b;
      w_divZero  = w_isDiv && (b == '0);
      w_accept   = (r_state == IDLE) && start && !cancel && (w_isMul || w_isDiv);
      w_launch   = w_accept && !w_divZero;
      w_lastStep = (r_count == CW'(W));
      w_commit   = (r_state == RUN) && w_lastStep && !cancel;
      w_wrHi     = (r_state == IDLE) && we && !start && (op == OP_MTHI);
      w_wrLo     = (r_state == IDLE) && we && !start && (op == OP_MTLO);
      w_runIsDiv = (r_op == OP_DIV) || (r_op == OP_DIVU);
   end

   // Next-state logic: RUN lasts W step cycles plus the fixup cycle, and a
   // cancel drops straight back to IDLE, beating the commit if coincident.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (w_launch) w_nextState = RUN;
         RUN:  if (cancel || w_lastStep) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // One radix-2 step of each algorithm on r_work = {upper, lower}.
   // Multiply: lower holds the multiplier and is consumed LSB first while
   // partial sums shift in from the top. Divide: upper is the partial
   // remainder, lower starts as the dividend and fills with quotient bits.
   // The remainder is always below the divisor, so only W bits of the
   // difference are ever needed.
   always_comb begin
      w_mulSum  = {1'b0, r_work[2*W-1:W]} + (r_work[0] ? {1'b0, r_opB} : '0);
      w_mulStep = {w_mulSum, r_work[W-1:1]};
      w_remSh   = r_work[2*W-1:W-1];
      w_remGe   = (w_remSh >= {1'b0, r_opB});
      w_diff    = w_remSh[W-1:0] - r_opB;
      w_divStep = w_remGe ? {w_diff, r_work[W-2:0], 1'b1}
                          : {w_remSh[W-1:0], r_work[W-2:0], 1'b0};
   end

   // Fixup: restore signs on the magnitude results, then either take the
   // result as-is or fold it into the current HI/LO for the accumulate ops.
   always_comb begin
      w_prod = r_negRes ? (~r_work + 1'b1) : r_work;
      w_quo  = r_negRes ? (~r_work[W-1:0] + 1'b1) : r_work[W-1:0];
      w_rem  = r_negRem ? (~r_work[2*W-1:W] + 1'b1) : r_work[2*W-1:W];
      case (r_op)
         OP_DIV,
         OP_DIVU:  w_result = {w_rem, w_quo};
         OP_MADD,
         OP_MADDU: w_result = {r_hi, r_lo} + w_prod;
         OP_MSUB,
         OP_MSUBU: w_result = {r_hi, r_lo} - w_prod;
         default:  w_result = w_prod;
      endcase
   end

   // Datapath registers. Working state is kept apart from HI/LO so the
   // architectural registers only change on commit or an idle mthi/mtlo.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= '0;
         r_op     <= '0;
         r_work   <= '0;
         r_opB    <= '0;
         r_negRes <= 1'b0;
         r_negRem <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_launch) begin
            r_work   <= {{W{1'b0}}, w_aMag};
            r_opB    <= w_bMag;
            r_op     <= op;
            r_negRes <= w_aNeg ^ w_bNeg;
            r_negRem <= w_aNeg;
            r_count  <= '0;
         end else if (r_state == RUN) begin
            if (cancel || w_lastStep) begin
               r_count <= '0;
            end else begin
               r_count <= r_count + CW'(1);
               r_work  <= w_runIsDiv ? w_divStep : w_mulStep;
            end
         end
         if (w_commit) begin
            r_hi <= w_result[2*W-1:W];
            r_lo <= w_result[W-1:0];
         end else if (w_wrHi) begin
            r_hi <= a;
         end else if (w_wrLo) begin
            r_lo <= a;
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_iter_mdu.sv
// ---------------------------------------------------------------------------
// tb_iter_mdu
// Self-checking bench for iter_mdu (W=32). Expected HI/LO pairs come from a
// behavioural model and are queued when an op is launched, then popped and
// compared when done pulses. Directed cases cover the listed scenarios;
// a short random section exercises all arithmetic ops.
// ---------------------------------------------------------------------------
module tb_iter_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         we;
   logic         cancel;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           checks   = 0;
   int           failures = 0;
   logic [63:0]  sbQ[$];
   logic [31:0]  mdlHi;
   logic [31:0]  mdlLo;

   iter_mdu #(.W(W), .EN_MACC(1'b1)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .we     (we),
      .cancel (cancel),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference for the {hi,lo} result of an arithmetic op.
   function automatic logic [63:0] modelResult(input logic [3:0] mOp,
                                               input logic [31:0] mA,
                                               input logic [31:0] mB,
                                               input logic [63:0] cur);
      logic [63:0] sProd;
      logic [63:0] uProd;
      int ia, ib, iq, ir;
      sProd = {{32{mA[31]}}, mA} * {{32{mB[31]}}, mB};
      uProd = {32'b0, mA} * {32'b0, mB};
      ia = mA;
      ib = mB;
      case (mOp)
         4'd1:  return sProd;
         4'd5:  return uProd;
         4'd2: begin
            if (mB == 32'd0) return cur;
            if (mA == 32'h8000_0000 && mB == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            iq = ia / ib;
            ir = ia % ib;
            return {ir, iq};
         end
         4'd6: begin
            if (mB == 32'd0) return cur;
            return {mA % mB, mA / mB};
         end
         4'd7:  return cur + sProd;
         4'd8:  return cur + uProd;
         4'd9:  return cur - sProd;
         4'd10: return cur - uProd;
         default: return cur;
      endcase
   endfunction

   // Drive a one-cycle start; when push is set the expected result is queued.
   task automatic applyStimulus(input logic [3:0] iOp, input logic [31:0] iA,
                                input logic [31:0] iB, input bit push);
      if (push) sbQ.push_back(modelResult(iOp, iA, iB, {mdlHi, mdlLo}));
      start = 1'b1;
      op    = iOp;
      a     = iA;
      b     = iB;
      tick();
      start = 1'b0;
      op    = 4'd0;
      a     = '0;
      b     = '0;
   endtask

   // Idle-state mthi/mtlo write; the model follows.
   task automatic writeHiLo(input logic [3:0] iOp, input logic [31:0] iA);
      we = 1'b1;
      op = iOp;
      a  = iA;
      tick();
      we = 1'b0;
      op = 4'd0;
      a  = '0;
      if (iOp == 4'd3) mdlHi = iA;
      if (iOp == 4'd4) mdlLo = iA;
   endtask

   // Wait (bounded) for the op to finish, count busy cycles, then pop the
   // scoreboard and compare. Optionally pokes an mthi write mid-run, which
   // must be ignored. Leaves time in the done cycle.
   task automatic waitDone(input bit poke);
      int n;
      logic [63:0] expVal;
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (n == W / 2) begin
            checkOutput("hiHeld", hi, mdlHi);
            checkOutput("loHeld", lo, mdlLo);
         end
         we = poke && (n == 5);
         op = (poke && n == 5) ? 4'd3 : 4'd0;
         a  = $urandom;
         tick();
      end
      we = 1'b0;
      op = 4'd0;
      a  = '0;
      checkOutput("busyCycles", n, W + 1);
      checkOutput("doneHigh", done, 1);
      checkOutput("sbDepth", sbQ.size(), 1);
      if (sbQ.size() > 0) begin
         expVal = sbQ.pop_front();
         checkOutput("resHi", hi, expVal[63:32]);
         checkOutput("resLo", lo, expVal[31:0]);
         mdlHi = expVal[63:32];
         mdlLo = expVal[31:0];
      end
   endtask

   logic [3:0]  opList [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
   logic [3:0]  rOp;
   logic [31:0] rA;
   logic [31:0] rB;

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      we     = 1'b0;
      cancel = 1'b0;
      op     = 4'd0;
      a      = '0;
      b      = '0;
      mdlHi  = '0;
      mdlLo  = '0;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rstHi", hi, 0);
      checkOutput("rstLo", lo, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);

      // mult -1 * 2
      applyStimulus(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
      waitDone(1'b0);
      checkOutput("multHi", hi, 32'hFFFF_FFFF);
      checkOutput("multLo", lo, 32'hFFFF_FFFE);
      tick();
      checkOutput("doneDrop", done, 0);

      // divu by zero is a no-op
      applyStimulus(4'd6, 32'd7, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("div0Busy", busy, 0);
         checkOutput("div0Done", done, 0);
         tick();
      end
      checkOutput("div0Hi", hi, mdlHi);
      checkOutput("div0Lo", lo, mdlLo);

      // div -7 / 2
      applyStimulus(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
      waitDone(1'b0);
      checkOutput("divLo", lo, 32'hFFFF_FFFD);
      checkOutput("divHi", hi, 32'hFFFF_FFFF);
      tick();

      // mthi/mtlo then maddu with carry into hi
      writeHiLo(4'd3, 32'd5);
      writeHiLo(4'd4, 32'hFFFF_FFFF);
      checkOutput("mthi", hi, 32'd5);
      checkOutput("mtlo", lo, 32'hFFFF_FFFF);
      applyStimulus(4'd8, 32'd1, 32'd1, 1'b1);
      waitDone(1'b0);
      checkOutput("madduHi", hi, 32'd6);
      checkOutput("madduLo", lo, 32'd0);
      tick();

      // mtlo 9, multu cancelled at RUN cycle 10
      writeHiLo(4'd4, 32'd9);
      applyStimulus(4'd5, 32'd3, 32'd4, 1'b0);
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checkOutput("cancelBusy", busy, 0);
      checkOutput("cancelLo", lo, 32'd9);
      for (int i = 0; i < W + 4; i++) begin
         checkOutput("cancelNoDone", done, 0);
         tick();
      end

      // cancel on the commit edge wins over the commit
      applyStimulus(4'd1, 32'd7, 32'd9, 1'b0);
      repeat (W) tick();
      checkOutput("lastBusy", busy, 1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checkOutput("cCommitBusy", busy, 0);
      checkOutput("cCommitDone", done, 0);
      checkOutput("cCommitHi", hi, mdlHi);
      checkOutput("cCommitLo", lo, mdlLo);

      // reset in the middle of a divide
      applyStimulus(4'd2, 32'd1000, 32'd7, 1'b0);
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mdlHi = '0;
      mdlLo = '0;
      checkOutput("midRstHi", hi, 0);
      checkOutput("midRstLo", lo, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstDone", done, 0);

      // start with mthi op plus we in the same idle cycle: nothing happens
      start = 1'b1;
      we    = 1'b1;
      op    = 4'd3;
      a     = 32'h0000_ABCD;
      tick();
      start = 1'b0;
      we    = 1'b0;
      op    = 4'd0;
      checkOutput("startWeHi", hi, 0);
      checkOutput("startWeBusy", busy, 0);

      // illegal opcodes are ignored
      applyStimulus(4'd0, 32'd3, 32'd3, 1'b0);
      checkOutput("illegal0Busy", busy, 0);
      applyStimulus(4'd15, 32'd3, 32'd3, 1'b0);
      checkOutput("illegal15Busy", busy, 0);

      // most-negative / -1, then a back-to-back start on the done cycle
      applyStimulus(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      waitDone(1'b0);
      checkOutput("ovfLo", lo, 32'h8000_0000);
      checkOutput("ovfHi", hi, 32'd0);
      applyStimulus(4'd1, 32'd5, 32'hFFFF_FFFD, 1'b1);
      checkOutput("b2bBusy", busy, 1);
      checkOutput("b2bDoneDrop", done, 0);
      waitDone(1'b1);
      tick();

      // random mix of all arithmetic ops
      for (int i = 0; i < 16; i++) begin
         rOp = opList[$urandom_range(0, 7)];
         rA  = $urandom;
         rB  = $urandom;
         if (i % 4 == 0) rB = 32'hFFFF_FFFF;
         if (i % 5 == 1) rA = 32'h8000_0000;
         if ((rOp == 4'd2 || rOp == 4'd6) && rB == 32'd0) rB = 32'd1;
         applyStimulus(rOp, rA, rB, 1'b1);
         waitDone(i % 2 == 0);
         if (i % 3 != 0) begin
            tick();
            checkOutput("rndDoneDrop", done, 0);
         end
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
